// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: FSM states, tag width default,
// instruction/word types and compare-flag bit positions.
package alu_arbiter_pkg;

  localparam int TAG_W_DEF = 4;
  localparam int INSTR_W   = 8;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [31:0]        word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam int CMP_EQ = 0;
  localparam int CMP_NE = 1;
  localparam int CMP_LT = 2;
  localparam int CMP_GE = 3;

  localparam instr_t INSTR_ADD    = 8'h01;
  localparam instr_t INSTR_SUB    = 8'h02;
  localparam instr_t INSTR_BRANCH = 8'h04;

endpackage

// File: rtl/alu_arbiter_pick.sv
// alu_arb_pick: combinational two-way grant selector. last_is_1 names the port
// most recently accepted; under contention in IDLE the other port wins.
module alu_arb_pick
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_is_1,
  input  arb_state_e state,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (state)
      LOCK0: grant = {1'b0, valid[0]};
      LOCK1: grant = {valid[1], 1'b0};
      IDLE: begin
        if (valid == 2'b11) begin
          grant = last_is_1 ? 2'b01 : 2'b10;
        end else begin
          grant = valid;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared, one-cycle-latency ALU, with lock
// ownership and a single in-flight response slot. Define ALU_ARB_RR_EN for
// round-robin contention; otherwise port 0 always wins in IDLE.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_lock,
  input  instr_t           req0_instr_type,
  input  word_t            req0_rs1,
  input  word_t            req0_rs2,
  input  word_t            req0_imm,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_lock,
  input  instr_t           req1_instr_type,
  input  word_t            req1_rs1,
  input  word_t            req1_rs2,
  input  word_t            req1_imm,
  input  logic [TAG_W-1:0] req1_tag,
  output instr_t           alu_instr_type,
  output word_t            alu_rs1,
  output word_t            alu_rs2,
  output word_t            alu_imm,
  input  logic [3:0]       alu_compare,
  input  word_t            alu_eval,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [3:0]       rsp_compare,
  output word_t            rsp_eval
);

  arb_state_e       state_q, state_d;
  logic             infl_valid_q, infl_valid_d;
  logic             infl_id_q, infl_id_d;
  logic [TAG_W-1:0] infl_tag_q, infl_tag_d;
  logic [1:0]       grant_raw;
  logic [1:0]       grant;
  logic             pick_last;

  alu_arb_pick u_pick (
    .valid     ({req1_valid, req0_valid}),
    .last_is_1 (pick_last),
    .state     (state_q),
    .grant     (grant_raw)
  );

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (grant[1]) begin
      last_d = 1'b1;
    end else if (grant[0]) begin
      last_d = 1'b0;
    end else begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign pick_last = last_q;
`else
  assign pick_last = 1'b1;
`endif

  // Nothing is accepted while reset is high.
  assign grant      = reset ? 2'b00 : grant_raw;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_instr_type = '0;
    alu_rs1        = '0;
    alu_rs2        = '0;
    alu_imm        = '0;
    if (grant[0]) begin
      alu_instr_type = req0_instr_type;
      alu_rs1        = req0_rs1;
      alu_rs2        = req0_rs2;
      alu_imm        = req0_imm;
    end else if (grant[1]) begin
      alu_instr_type = req1_instr_type;
      alu_rs1        = req1_rs1;
      alu_rs2        = req1_rs2;
      alu_imm        = req1_imm;
    end else begin
      alu_instr_type = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    infl_valid_d = 1'b0;
    infl_id_d    = infl_id_q;
    infl_tag_d   = infl_tag_q;
    if (grant[0]) begin
      state_d      = req0_lock ? LOCK0 : IDLE;
      infl_valid_d = 1'b1;
      infl_id_d    = 1'b0;
      infl_tag_d   = req0_tag;
    end else if (grant[1]) begin
      state_d      = req1_lock ? LOCK1 : IDLE;
      infl_valid_d = 1'b1;
      infl_id_d    = 1'b1;
      infl_tag_d   = req1_tag;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      infl_valid_q <= 1'b0;
      infl_id_q    <= 1'b0;
      infl_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      infl_valid_q <= infl_valid_d;
      infl_id_q    <= infl_id_d;
      infl_tag_q   <= infl_tag_d;
    end
  end

  // A response in flight when reset arrives is dropped immediately.
  assign rsp_valid   = infl_valid_q & ~reset;
  assign rsp_id      = infl_id_q;
  assign rsp_tag     = infl_tag_q;
  assign rsp_compare = alu_compare;
  assign rsp_eval    = alu_eval;

endmodule
